// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the EX stage: multi-cycle MULT/MULTU/DIV/DIVU
// with deferred commit, plus single-cycle MTHI/MTLO.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [31:0]   r_hi, r_lo, w_hi_next, w_lo_next;
  logic [31:0]   r_pend_hi, r_pend_lo, w_pend_hi_next, w_pend_lo_next;
  state_t        w_state;
  logic          w_accept;

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_den_s, w_den_u;
  logic [31:0] w_q_mag, w_r_mag, w_quot_s, w_rem_s, w_quot_u, w_rem_u;

  assign w_state  = (r_cnt != '0) ? S_RUN : S_IDLE;
  assign busy     = (r_cnt != '0);
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;
  assign w_accept = start & ~flush & ~busy & (op >= OP_MULT) & (op <= OP_MTLO);

  // Low 64 bits of the sign-extended product equal the two's complement result.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly;
  // zero divisors are replaced by 1 only to keep the datapath defined.
  assign w_abs_a  = A[31] ? (~A + 32'd1) : A;
  assign w_abs_b  = B[31] ? (~B + 32'd1) : B;
  assign w_den_s  = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_q_mag  = w_abs_a / w_den_s;
  assign w_r_mag  = w_abs_a % w_den_s;
  assign w_quot_s = (A[31] ^ B[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem_s  = A[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_den_u  = (B == 32'd0) ? 32'd1 : B;
  assign w_quot_u = A / w_den_u;
  assign w_rem_u  = A % w_den_u;

  always_comb begin
    w_cnt_next     = r_cnt;
    w_hi_next      = r_hi;
    w_lo_next      = r_lo;
    w_pend_hi_next = r_pend_hi;
    w_pend_lo_next = r_pend_lo;
    case (w_state)
      S_RUN: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_hi_next = r_pend_hi;
          w_lo_next = r_pend_lo;
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            OP_MULT: begin
              w_pend_hi_next = w_prod_s[63:32];
              w_pend_lo_next = w_prod_s[31:0];
              w_cnt_next     = MULT_LD;
            end
            OP_MULTU: begin
              w_pend_hi_next = w_prod_u[63:32];
              w_pend_lo_next = w_prod_u[31:0];
              w_cnt_next     = MULT_LD;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
              if (B == 32'd0) begin
                w_pend_hi_next = r_hi;
                w_pend_lo_next = r_lo;
              end else if (op == OP_DIV) begin
                w_pend_hi_next = w_rem_s;
                w_pend_lo_next = w_quot_s;
              end else begin
                w_pend_hi_next = w_rem_u;
                w_pend_lo_next = w_quot_u;
              end
              w_cnt_next = DIV_LD;
            end
            OP_MTHI: w_hi_next = A;
            OP_MTLO: w_lo_next = A;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_hi      <= w_hi_next;
      r_lo      <= w_lo_next;
      r_pend_hi <= w_pend_hi_next;
      r_pend_lo <= w_pend_lo_next;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO and busy length are queued at
// issue time and compared when busy drops.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, flush, busy;
  logic [2:0]  op;
  logic [31:0] A, B, hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ch, input logic [31:0] cl,
                                output logic [31:0] nh, output logic [31:0] nl, output int nc);
    longint p, q, r;
    logic [63:0] pu;
    nh = ch;
    nl = cl;
    nc = 0;
    case (o)
      3'd1: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        nh = p[63:32];
        nl = p[31:0];
        nc = MC;
      end
      3'd2: begin
        pu = 64'(a);
        pu = pu * 64'(b);
        nh = pu[63:32];
        nl = pu[31:0];
        nc = MC;
      end
      3'd3: begin
        if (b != 32'd0) begin
          p  = longint'($signed(a));
          q  = p / longint'($signed(b));
          r  = p % longint'($signed(b));
          nl = q[31:0];
          nh = r[31:0];
        end
        nc = DC;
      end
      3'd4: begin
        if (b != 32'd0) begin
          nl = a / b;
          nh = a % b;
        end
        nc = DC;
      end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
  endfunction

  // Issues one op; optionally pokes a MULT start while busy, which must be ignored.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit inject);
    logic [31:0] nh, nl;
    logic [63:0] e;
    int nc, cnt, ec;
    model(o, a, b, m_hi, m_lo, nh, nl, nc);
    exp_q.push_back({nh, nl});
    cyc_q.push_back(nc);
    start = 1'b1; op = o; A = a; B = b;
    tick;
    start = 1'b0; op = 3'd0;
    cnt = 0;
    while (busy && cnt < 64) begin
      check({tag, "_hold_hi"}, hi_out, m_hi);
      check({tag, "_hold_lo"}, lo_out, m_lo);
      if (inject && cnt == 1) begin
        start = 1'b1; op = 3'd1; A = 32'h0000_0100; B = 32'h0000_0100;
      end else begin
        start = 1'b0; op = 3'd0;
      end
      cnt++;
      tick;
    end
    start = 1'b0; op = 3'd0;
    ec = cyc_q.pop_front();
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(ec));
    e = exp_q.pop_front();
    check({tag, "_hi"}, hi_out, e[63:32]);
    check({tag, "_lo"}, lo_out, e[31:0]);
    m_hi = nh;
    m_lo = nl;
    $display("%s op=%0d A=%h B=%h -> HI=%h LO=%h busy_cycles=%0d", tag, o, a, b, hi_out, lo_out, cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) tick;
    @(negedge clk);
    reset = 1'b0;
    tick;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi_out, 32'd0);
    check("reset_lo", lo_out, 32'd0);

    do_op("mthi", 3'd5, 32'h0000_1234, 32'd0, 1'b0);
    do_op("mtlo", 3'd6, 32'h0000_5678, 32'd0, 1'b0);
    check("mt_hi_const", hi_out, 32'h0000_1234);

    do_op("mult_signed", 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_signed_hi_const", hi_out, 32'hFFFF_FFFF);
    check("mult_signed_lo_const", lo_out, 32'hFFFF_FFEB);

    // Asynchronous reset in the second busy cycle of a MULT.
    start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd5;
    tick;
    start = 1'b0; op = 3'd0;
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    tick;
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi_out, 32'd0);
    check("rst_mid_lo", lo_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (8) tick;
    check("rst_no_commit_busy", {31'd0, busy}, 32'd0);
    check("rst_no_commit_hi", hi_out, 32'd0);
    check("rst_no_commit_lo", lo_out, 32'd0);
    $display("reset mid-run: busy=%b HI=%h LO=%h", busy, hi_out, lo_out);

    do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo_const", lo_out, 32'hFFFF_FFFD);
    do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo_const", lo_out, 32'h8000_0000);
    check("div_ovf_hi_const", hi_out, 32'd0);

    do_op("mthi2", 3'd5, 32'h0000_AAAA, 32'd0, 1'b0);
    do_op("mtlo2", 3'd6, 32'h0000_5555, 32'd0, 1'b0);
    do_op("divu_by_zero_with_start_busy", 3'd4, 32'd9, 32'd0, 1'b1);
    check("divz_hi_const", hi_out, 32'h0000_AAAA);

    // start with flush in the same cycle must change nothing.
    start = 1'b1; flush = 1'b1; op = 3'd6; A = 32'd1;
    tick;
    start = 1'b0; flush = 1'b0; op = 3'd0;
    check("flush_lo", lo_out, m_lo);
    check("flush_hi", hi_out, m_hi);
    check("flush_busy", {31'd0, busy}, 32'd0);
    $display("flush MTLO A=1: busy=%b HI=%h LO=%h", busy, hi_out, lo_out);

    do_op("mult_b2b", 3'd1, 32'd2, 32'd3, 1'b0);
    check("b2b_lo6", lo_out, 32'd6);
    do_op("div_b2b", 3'd3, 32'd6, 32'd4, 1'b0);
    check("b2b_lo1", lo_out, 32'd1);
    check("b2b_hi2", hi_out, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
